// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the time-shared display scheduler
package disp_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DWELL_1S = 50_000_000;
  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, SHOW, RELEASE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set req at or after ptr, wrapping mod NREQ
//   req in NREQ, ptr in start index; sel out chosen index, vld out any req set
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   sel,
  output logic            vld
);
  logic [IW-1:0] j;
  always_comb begin
    sel = '0;
    vld = 1'b0;
    j = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!vld && req[j]) begin
        sel = j;
        vld = 1'b1;
      end
      j = (j == IW'(NREQ - 1)) ? '0 : j + 1'b1;
    end
  end
endmodule

// File: rtl/disp_sched.sv
// disp_sched: round-robin time-sharing of the display value among NREQ requesters
//   clk, rst_n (async active-low); req level requests; data packed values (i at i*DATA_W)
//   grant one-hot owner; X latched value; blank display off; done/done_id/aborted slot-end pulse
//   DISP_SCHED_PREEMPT_EN: requester 0 preempts any other slot and is granted next
module disp_sched import disp_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DWELL = DWELL_1S
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   data,
  output logic [NREQ-1:0]          grant,
  output logic [DATA_W-1:0]        X,
  output logic                     blank,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     aborted
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  state_t state, state_nxt;
  logic [IW-1:0] cur, rr_ptr, sel;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] d [NREQ];
  logic vld, pend0, pre, rel_abort, leave;
  for (genvar i = 0; i < NREQ; i++) begin : g_d
    assign d[i] = data[i*DATA_W +: DATA_W];
  end
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req),
    .ptr(pend0 ? '0 : rr_ptr),
    .sel(sel),
    .vld(vld)
  );
`ifdef DISP_SCHED_PREEMPT_EN
  assign pre = state == SHOW && cur != '0 && req[0];
`else
  assign pre = 1'b0;
`endif
  assign rel_abort = !req[cur] || pre;
  assign leave = state == SHOW && (rel_abort || cnt == '0);
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (vld ? SHOW : IDLE) :
                state == SHOW ? (leave ? RELEASE : SHOW) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      X <= '0;
      blank <= 1'b1;
      done <= 1'b0;
      done_id <= '0;
      aborted <= 1'b0;
      rr_ptr <= '0;
      cnt <= '0;
      cur <= '0;
      pend0 <= 1'b0;
    end else begin
      done <= 1'b0;
      aborted <= 1'b0;
      if (state == IDLE && vld) begin
        cur <= sel;
        grant <= NREQ'(1) << sel;
        X <= d[sel];
        blank <= 1'b0;
        cnt <= CW'(DWELL - 1);
        pend0 <= 1'b0;
        if (pend0) rr_ptr <= IW'(1);
      end else if (leave) begin
        grant <= '0;
        blank <= 1'b1;
        done <= 1'b1;
        done_id <= cur;
        aborted <= rel_abort;
        rr_ptr <= cur == IW'(NREQ - 1) ? '0 : cur + 1'b1;
        pend0 <= pre;
      end else if (state == SHOW) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: directed checks of arbitration order, dwell, abort, preemption and reset
module tb_disp_sched;
  localparam int NREQ = 4;
  localparam int DATA_W = 8;
  localparam int DWELL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DATA_W-1:0] data = {8'h33, 8'h22, 8'h11, 8'h05};
  logic [NREQ-1:0] grant;
  logic [DATA_W-1:0] X;
  logic blank, done, aborted;
  logic [1:0] done_id;
  int n_chk = 0;
  int n_fail = 0;
  disp_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .DWELL(DWELL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data(data),
    .grant(grant),
    .X(X),
    .blank(blank),
    .done(done),
    .done_id(done_id),
    .aborted(aborted)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rel(input int id, input logic ab);
    check("rel_grant", grant, 0);
    check("rel_blank", blank, 1);
    check("rel_done", done, 1);
    check("rel_done_id", done_id, id);
    check("rel_aborted", aborted, ab);
  endtask
  task automatic full_slot(input int k, input logic [7:0] v);
    tick;
    check("slot_grant", grant, 1 << k);
    check("slot_X", X, v);
    check("slot_blank", blank, 0);
    check("slot_done", done, 0);
    repeat (DWELL - 1) begin
      tick;
      check("slot_hold", grant, 1 << k);
    end
    tick;
    chk_rel(k, 1'b0);
    tick;
    check("gap_grant", grant, 0);
    check("gap_done", done, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_X", X, 0);
    check("rst_blank", blank, 1);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_aborted", aborted, 0);
    rst_n = 1'b1;
    req = 4'b1111;
    full_slot(0, 8'h05);
    full_slot(1, 8'h11);
    full_slot(2, 8'h22);
    full_slot(3, 8'h33);
    full_slot(0, 8'h05);
    tick;
    check("drop_grant", grant, 4'b0010);
    tick;
    tick;
    req = 4'b1101;
    tick;
    chk_rel(1, 1'b1);
    tick;
    req = 4'b0100;
    data[23:16] = 8'h85;
    tick;
    check("pre_grant", grant, 4'b0100);
    check("pre_X", X, 8'h85);
    tick;
    req = 4'b0101;
`ifdef DISP_SCHED_PREEMPT_EN
    tick;
    chk_rel(2, 1'b1);
`else
    repeat (2) begin
      tick;
      check("nopre_hold", grant, 4'b0100);
    end
    tick;
    chk_rel(2, 1'b0);
`endif
    tick;
    tick;
    check("after_pre_grant", grant, 4'b0001);
    check("after_pre_X", X, 8'h05);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_grant", grant, 0);
    check("async_X", X, 0);
    check("async_blank", blank, 1);
    req = 4'b1111;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;
    check("post_rst_grant", grant, 4'b0001);
    rst_n = 1'b0;
    req = 4'b0100;
    #2;
    rst_n = 1'b1;
    tick;
    check("t2_grant", grant, 4'b0100);
    check("t2_X", X, 8'h85);
    check("t2_blank", blank, 0);
    data[23:16] = 8'h10;
    repeat (DWELL - 1) begin
      tick;
      check("t6_X_hold", X, 8'h85);
      check("t2_hold", grant, 4'b0100);
    end
    tick;
    chk_rel(2, 1'b0);
    tick;
    check("idle_blank", blank, 1);
    check("idle_X", X, 8'h85);
    check("idle_done", done, 0);
    tick;
    check("t6_new_X", X, 8'h10);
    check("t6_grant", grant, 4'b0100);
    req = 4'b0000;
    tick;
    chk_rel(2, 1'b1);
    tick;
    check("end_done", done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
